// File: rtl/ex_mem_req_unit.sv
// EX-stage data-memory request generator: req/addr_ok/data_ok handshake with bounded
// outstanding requests and discard of responses belonging to flushed requests.
module ex_mem_req_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_is_load,
  input  logic                             in_is_store,
  input  logic [1:0]                       in_size,
  input  logic [ADDR_W-1:0]                in_addr,
  input  logic [DATA_W-1:0]                in_wdata,
  input  logic                             in_cancel,
  input  logic                             flush,
  output logic                             ale_o,
  output logic                             req_o,
  output logic                             req_wr,
  output logic [1:0]                       req_size,
  output logic [ADDR_W-1:0]                req_addr,
  output logic [DATA_W/8-1:0]              req_wstrb,
  output logic [DATA_W-1:0]                req_wdata,
  input  logic                             addr_ok,
  input  logic                             data_ok,
  output logic                             resp_valid,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt
);

  localparam int LANES = DATA_W / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int CW    = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   live, discard, live_n, discard_n;
  logic [CW-1:0]   live_tmp, disc_tmp;
  logic            misaligned, needs_req, full, latch;
  logic            acc_live, acc_disc, dec_live, dec_disc;
  logic [OFFW-1:0] off;
  logic [LANES-1:0]  wstrb_n;
  logic [DATA_W-1:0] wdata_n;

  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = |in_addr[1:0];
      default: misaligned = (DATA_W != 64) || (|in_addr[2:0]);
    endcase
  end

  assign ale_o     = in_valid & (in_is_load | in_is_store) & misaligned;
  assign needs_req = (in_is_load | in_is_store) & ~ale_o & ~in_cancel;
  assign outst_cnt = live + discard;
  assign full      = outst_cnt >= CW'(MAX_OUTST);
  assign req_o     = (state != IDLE) & ~full;
  assign off       = in_addr[OFFW-1:0];

  always_comb begin
    wstrb_n = '0;
    wdata_n = '0;
    case (in_size)
      2'd0: begin
        wstrb_n = LANES'(1) << off;
        wdata_n = {LANES{in_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_n = LANES'(3) << off;
        wdata_n = {(DATA_W/16){in_wdata[15:0]}};
      end
      2'd2: begin
        wstrb_n = LANES'(4'hF) << off;
        wdata_n = {(DATA_W/32){in_wdata[31:0]}};
      end
      default: begin
        wstrb_n = '1;
        wdata_n = in_wdata;
      end
    endcase
    if (!in_is_store) wstrb_n = '0;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    latch    = 1'b0;
    acc_live = 1'b0;
    acc_disc = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~flush;
        if (in_valid & in_ready & needs_req) begin
          latch   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (req_o & addr_ok) begin
          if (flush) begin
            acc_disc = 1'b1;
            state_n  = IDLE;
          end else begin
            acc_live = 1'b1;
            in_ready = 1'b1;
            if (in_valid & needs_req) latch = 1'b1;
            else                      state_n = IDLE;
          end
        end else if (flush) begin
          // an already presented request stays up until the bus takes it
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (req_o & addr_ok) begin
          acc_disc = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // responses return in order, so flushed requests are always the oldest ones
  always_comb begin
    dec_disc   = data_ok & (discard != '0);
    dec_live   = data_ok & (discard == '0) & (live != '0);
    resp_valid = dec_live;
    live_tmp   = live - CW'(dec_live) + CW'(acc_live);
    disc_tmp   = discard - CW'(dec_disc) + CW'(acc_disc);
    if (flush) begin
      live_n    = '0;
      discard_n = disc_tmp + live_tmp;
    end else begin
      live_n    = live_tmp;
      discard_n = disc_tmp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      live      <= '0;
      discard   <= '0;
      req_wr    <= 1'b0;
      req_size  <= '0;
      req_addr  <= '0;
      req_wstrb <= '0;
      req_wdata <= '0;
    end else begin
      state   <= state_n;
      live    <= live_n;
      discard <= discard_n;
      if (latch) begin
        req_wr    <= in_is_store;
        req_size  <= in_size;
        req_addr  <= in_addr;
        req_wstrb <= wstrb_n;
        req_wdata <= wdata_n;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_req_unit.sv
// Bench for ex_mem_req_unit: queue-based reference model with randomized stimulus,
// plus literal expectations on a 32-bit and a 64-bit instance.
module tb_ex_mem_req_unit;

  localparam int MAX = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_is_load, in_is_store, in_cancel, flush, addr_ok, data_ok;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        in_ready, ale_o, req_o, req_wr, resp_valid;
  logic [1:0]  req_size, outst_cnt;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;

  logic        w_in_valid, w_in_is_load, w_in_is_store, w_in_cancel, w_flush, w_addr_ok, w_data_ok;
  logic [1:0]  w_in_size;
  logic [31:0] w_in_addr;
  logic [63:0] w_in_wdata;
  logic        w_in_ready, w_ale_o, w_req_o, w_req_wr, w_resp_valid;
  logic [1:0]  w_req_size, w_outst_cnt;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic [7:0]  w_req_wstrb;

  ex_mem_req_unit #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(MAX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_size(in_size),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_cancel(in_cancel), .flush(flush),
    .ale_o(ale_o), .req_o(req_o), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .resp_valid(resp_valid), .outst_cnt(outst_cnt)
  );

  ex_mem_req_unit #(.DATA_W(64), .ADDR_W(32), .MAX_OUTST(2)) dut64 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_is_load(w_in_is_load), .in_is_store(w_in_is_store), .in_size(w_in_size),
    .in_addr(w_in_addr), .in_wdata(w_in_wdata), .in_cancel(w_in_cancel), .flush(w_flush),
    .ale_o(w_ale_o), .req_o(w_req_o), .req_wr(w_req_wr), .req_size(w_req_size),
    .req_addr(w_req_addr), .req_wstrb(w_req_wstrb), .req_wdata(w_req_wdata),
    .addr_ok(w_addr_ok), .data_ok(w_data_ok), .resp_valid(w_resp_valid), .outst_cnt(w_outst_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one entry per accepted request in issue order, flagged live or flushed.
  bit        q[$];
  bit        pend, doomed;
  bit        p_wr;
  bit [1:0]  p_size;
  bit [31:0] p_addr, p_wdata;
  bit [3:0]  p_wstrb;

  function automatic bit m_ale();
    if (!(in_valid && (in_is_load || in_is_store))) return 1'b0;
    if (in_size == 2'd3) return 1'b1;
    return (in_addr % (32'd1 << in_size)) != 0;
  endfunction

  function automatic bit m_req();
    return pend && (q.size() < MAX);
  endfunction

  function automatic bit m_ready();
    if (!pend) return !flush;
    if (doomed) return 1'b0;
    return m_req() && addr_ok && !flush;
  endfunction

  task automatic compare();
    if (reset) return;
    chk("ale_o", ale_o, m_ale());
    chk("in_ready", in_ready, m_ready());
    chk("req_o", req_o, m_req());
    chk("resp_valid", resp_valid, data_ok && q.size() > 0 && q[0]);
    chk("outst_cnt", outst_cnt, q.size());
    if (pend) begin
      chk("req_wr", req_wr, p_wr);
      chk("req_size", req_size, p_size);
      chk("req_addr", req_addr, p_addr);
      chk("req_wstrb", req_wstrb, p_wstrb);
      if (p_wr) chk("req_wdata", req_wdata, p_wdata);
    end
  endtask

  task automatic update();
    bit acc, hs, nreq;
    int n, off;
    if (reset) begin
      q.delete();
      pend = 0;
      doomed = 0;
      return;
    end
    acc  = m_req() && addr_ok;
    hs   = in_valid && m_ready();
    nreq = (in_is_load || in_is_store) && !m_ale() && !in_cancel;
    if (data_ok && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(!doomed && !flush);
    if (flush) foreach (q[k]) q[k] = 1'b0;
    if (acc) pend = 0;
    else if (flush && pend) doomed = 1;
    if (hs && nreq) begin
      pend = 1;
      doomed = 0;
      p_wr = in_is_store;
      p_size = in_size;
      p_addr = in_addr;
      n = 1 << in_size;
      off = in_addr % 4;
      p_wstrb = '0;
      p_wdata = '0;
      for (int b = 0; b < 4; b++) begin
        if (in_is_store && b >= off && b < off + n) p_wstrb[b] = 1'b1;
        p_wdata[8*b +: 8] = in_wdata[8*(b % n) +: 8];
      end
    end
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_cancel = 0;
    in_size = 0; in_addr = 0; in_wdata = 0; flush = 0; addr_ok = 0; data_ok = 0;
  endtask

  task automatic op(input bit st, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
    in_valid = 1; in_is_load = !st; in_is_store = st; in_size = sz; in_addr = a; in_wdata = d;
  endtask

  task automatic w_idle();
    w_in_valid = 0; w_in_is_load = 0; w_in_is_store = 0; w_in_cancel = 0; w_in_size = 0;
    w_in_addr = 0; w_in_wdata = 0; w_flush = 0; w_addr_ok = 0; w_data_ok = 0;
  endtask

  task automatic w_store(input bit [1:0] sz, input bit [31:0] a, input bit [63:0] d);
    w_in_valid = 1; w_in_is_store = 1; w_in_size = sz; w_in_addr = a; w_in_wdata = d;
  endtask

  task automatic w_step();
    @(posedge clk);
    @(negedge clk);
    w_idle();
  endtask

  initial begin
    idle_in();
    w_idle();
    reset = 1;
    @(negedge clk);
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst req_o", req_o, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst outst_cnt", outst_cnt, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst req_addr", req_addr, 0);
    chk("rst req_wstrb", req_wstrb, 0);
    chk("rst req_wdata", req_wdata, 0);
    chk("rst req_wr", req_wr, 0);
    chk("rst64 req_o", w_req_o, 0);
    chk("rst64 in_ready", w_in_ready, 1);

    // store byte, lane 3
    op(1, 2'd0, 32'h1003, 32'hAB);
    #1; chk("t1 in_ready", in_ready, 1); chk("t1 req_o early", req_o, 0);
    tick();
    idle_in(); addr_ok = 1;
    #1; chk("t1 req_o", req_o, 1); chk("t1 wstrb", req_wstrb, 4'b1000);
    chk("t1 wdata", req_wdata, 32'hABABABAB);
    tick();
    idle_in(); data_ok = 1;
    #1; chk("t1 resp_valid", resp_valid, 1); chk("t1 cnt", outst_cnt, 1);
    tick();
    idle_in();

    // misaligned load word
    op(0, 2'd2, 32'h1002, 0);
    #1; chk("t2 ale_o", ale_o, 1); chk("t2 in_ready", in_ready, 1);
    tick();
    idle_in();
    #1; chk("t2 req_o", req_o, 0); chk("t2 cnt", outst_cnt, 0);
    tick();

    // three back-to-back loads against MAX_OUTST=2
    op(0, 2'd2, 32'h100, 0); tick();
    op(0, 2'd2, 32'h104, 0); addr_ok = 1;
    #1; chk("t3 req_o c1", req_o, 1); chk("t3 ready c1", in_ready, 1);
    tick();
    op(0, 2'd2, 32'h108, 0); addr_ok = 1;
    #1; chk("t3 req_o c2", req_o, 1);
    tick();
    idle_in();
    #1; chk("t3 req_o full", req_o, 0); chk("t3 cnt full", outst_cnt, 2);
    tick();
    idle_in(); data_ok = 1;
    #1; chk("t3 req_o dok", req_o, 0); chk("t3 resp_valid", resp_valid, 1);
    tick();
    idle_in(); addr_ok = 1;
    #1; chk("t3 req_o after", req_o, 1); chk("t3 addr", req_addr, 32'h108);
    tick();

    // flush with two live requests
    idle_in(); flush = 1;
    #1; chk("t4 cnt pre", outst_cnt, 2);
    tick();
    idle_in(); data_ok = 1;
    #1; chk("t4 rv0", resp_valid, 0); chk("t4 cnt2", outst_cnt, 2);
    tick();
    idle_in(); data_ok = 1;
    #1; chk("t4 rv1", resp_valid, 0); chk("t4 cnt1", outst_cnt, 1);
    tick();
    idle_in();
    #1; chk("t4 cnt0", outst_cnt, 0);
    tick();

    // flush while waiting for addr_ok
    op(1, 2'd2, 32'h2000, 32'hDEADBEEF); tick();
    idle_in(); flush = 1;
    #1; chk("t5 req_o", req_o, 1);
    tick();
    idle_in(); op(0, 2'd2, 32'h3000, 0);
    #1; chk("t5 hold req_o", req_o, 1); chk("t5 hold ready", in_ready, 0);
    chk("t5 hold addr", req_addr, 32'h2000);
    tick();
    idle_in(); flush = 1;
    #1; chk("t5 hold2 req_o", req_o, 1);
    tick();
    idle_in(); addr_ok = 1;
    #1; chk("t5 wstrb", req_wstrb, 4'hF); chk("t5 addr", req_addr, 32'h2000);
    tick();
    idle_in(); data_ok = 1;
    #1; chk("t5 cnt", outst_cnt, 1); chk("t5 rv", resp_valid, 0);
    tick();
    idle_in();
    #1; chk("t5 cnt0", outst_cnt, 0);
    tick();

    // randomized traffic against the model, with one mid-run reset
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      reset       = (i == 2000);
      in_valid    = $urandom_range(0, 99) < 60;
      in_is_load  = r < 4;
      in_is_store = r >= 4 && r < 8;
      in_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_addr     = $urandom;
      in_wdata    = $urandom;
      in_cancel   = $urandom_range(0, 99) < 10;
      flush       = $urandom_range(0, 99) < 7;
      addr_ok     = $urandom_range(0, 1) == 1;
      data_ok     = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
      tick();
    end
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      idle_in();
      addr_ok = 1;
      data_ok = q.size() > 0;
      tick();
    end
    idle_in();
    tick();

    // 64-bit lanes
    w_store(2'd1, 32'h1006, 64'h1234);
    #1; chk("w half ready", w_in_ready, 1); chk("w half ale", w_ale_o, 0);
    w_step();
    w_addr_ok = 1;
    #1; chk("w half req_o", w_req_o, 1); chk("w half wstrb", w_req_wstrb, 8'b1100_0000);
    chk("w half wdata", w_req_wdata, 64'h1234123412341234); chk("w half size", w_req_size, 1);
    w_step();
    w_store(2'd3, 32'h2004, 64'h1);
    #1; chk("w dword ale", w_ale_o, 1); chk("w dword ale ready", w_in_ready, 1);
    w_step();
    w_store(2'd3, 32'h2008, 64'h1122334455667788); w_data_ok = 1;
    #1; chk("w no req", w_req_o, 0); chk("w resp_valid", w_resp_valid, 1);
    w_step();
    w_addr_ok = 1;
    #1; chk("w dword req_o", w_req_o, 1); chk("w dword wstrb", w_req_wstrb, 8'hFF);
    chk("w dword wdata", w_req_wdata, 64'h1122334455667788);
    w_step();
    w_store(2'd2, 32'h300C, 64'hCAFEF00D);
    w_step();
    w_addr_ok = 1;
    #1; chk("w word req_o", w_req_o, 1); chk("w word wstrb", w_req_wstrb, 8'hF0);
    chk("w word wdata", w_req_wdata, 64'hCAFEF00DCAFEF00D);
    w_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
